// File: rtl/mips_alu_ctrl_dmem.sv
// Decode/execute/memory slice of a single-cycle MIPS32 datapath.
// Control, ALU and read path are combinational; only the 64x32 data memory is clocked.
module mips_alu_ctrl_dmem (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic [31:0] imm_ext,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        branch,
  output logic        pc_src,
  output logic        mem_write,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [31:0] mem_rdata,
  output logic [31:0] wb_data
);

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned AW     = 6;
  localparam int unsigned DW     = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic          alu_src;
  logic          memtoreg;
  logic [1:0]    aluop;
  logic [2:0]    alu_control;
  logic [DW-1:0] src_b;
  logic [AW-1:0] mem_idx;
  logic [DW-1:0] mem [DEPTH];

  // Main decoder
  always_comb begin
    reg_dst   = 1'b0;
    reg_write = 1'b0;
    alu_src   = 1'b0;
    memtoreg  = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    aluop     = 2'b00;
    unique case (opcode)
      OP_RTYPE: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        aluop     = 2'b10;
      end
      OP_LW: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        memtoreg  = 1'b1;
      end
      OP_SW: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OP_BEQ: begin
        branch = 1'b1;
        aluop  = 2'b01;
      end
      OP_ADDI: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decoder; aluop 11 is never produced and falls back to add
  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      2'b01: alu_control = ALU_SUB;
      2'b10: begin
        case (funct)
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          FN_ADD:  alu_control = ALU_ADD;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

  assign src_b = alu_src ? imm_ext : rd2;

  always_comb begin
    alu_result = '0;
    case (alu_control)
      ALU_AND: alu_result = rd1 & src_b;
      ALU_OR:  alu_result = rd1 | src_b;
      ALU_ADD: alu_result = rd1 + src_b;
      ALU_SUB: alu_result = rd1 - src_b;
      ALU_SLT: alu_result = ($signed(rd1) < $signed(src_b)) ? 32'd1 : 32'd0;
      default: alu_result = '0;
    endcase
  end

  assign zero   = (alu_result == '0);
  assign pc_src = branch & zero;

  // Word index; byte offset and upper address bits are dropped, wrapping at 256 bytes
  assign mem_idx = alu_result[7:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (mem_write) begin
      mem[mem_idx] <= rd2;
    end
  end

  assign mem_rdata = rst_n ? mem[mem_idx] : '0;
  assign wb_data   = memtoreg ? mem_rdata : alu_result;

endmodule

// File: tb/tb_mips_alu_ctrl_dmem.sv
// Scoreboard bench for mips_alu_ctrl_dmem: expectations queued at drive time, checked after settling.
module tb_mips_alu_ctrl_dmem;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] imm_ext;
  logic        reg_dst;
  logic        reg_write;
  logic        branch;
  logic        pc_src;
  logic        mem_write;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] mem_rdata;
  logic [31:0] wb_data;

  mips_alu_ctrl_dmem dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .rd1        (rd1),
    .rd2        (rd2),
    .imm_ext    (imm_ext),
    .reg_dst    (reg_dst),
    .reg_write  (reg_write),
    .branch     (branch),
    .pc_src     (pc_src),
    .mem_write  (mem_write),
    .alu_result (alu_result),
    .zero       (zero),
    .mem_rdata  (mem_rdata),
    .wb_data    (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef enum logic [3:0] {
    S_ALU, S_ZERO, S_RDATA, S_WB, S_REGDST, S_REGWR, S_BRANCH, S_PCSRC, S_MEMWR
  } sig_e;

  typedef struct {
    sig_e        sig;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      S_ALU:    return alu_result;
      S_ZERO:   return 32'(zero);
      S_RDATA:  return mem_rdata;
      S_WB:     return wb_data;
      S_REGDST: return 32'(reg_dst);
      S_REGWR:  return 32'(reg_write);
      S_BRANCH: return 32'(branch);
      S_PCSRC:  return 32'(pc_src);
      default:  return 32'(mem_write);
    endcase
  endfunction

  task automatic push(input sig_e s, input logic [31:0] v, input string tag);
    exp_t e;
    e.sig = s; e.exp = v; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    opcode = op; funct = fn; rd1 = a; rd2 = b; imm_ext = imm;
  endtask

  // Let combinational outputs settle, then pop and compare everything queued
  task automatic drain();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, observe(e.sig), e.exp);
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    drive(OP_SW, 6'd0, 32'd0, data, addr);
    push(S_MEMWR, 32'd1, "sw_memwr");
    push(S_REGWR, 32'd0, "sw_regwr");
    drain();
    @(posedge clk);
  endtask

  task automatic load(input logic [31:0] base, input logic [31:0] off,
                      input logic [31:0] exp, input string tag);
    @(negedge clk);
    drive(OP_LW, 6'd0, base, 32'h0BAD_0BAD, off);
    push(S_RDATA, exp, {tag, "_rdata"});
    push(S_WB, exp, {tag, "_wb"});
    drain();
  endtask

  initial begin
    rst_n = 1'b1;
    drive(OP_R, 6'b100000, 32'd0, 32'd0, 32'd0);
    #2 rst_n = 1'b0;
    push(S_RDATA, 32'd0, "reset_rdata");
    drain();
    @(negedge clk);
    rst_n = 1'b1;

    // R-type add/and/or
    @(negedge clk);
    drive(OP_R, 6'b100000, 32'd5, 32'd7, 32'd99);
    push(S_ALU, 32'd12, "add_alu");
    push(S_REGWR, 32'd1, "add_regwr");
    push(S_REGDST, 32'd1, "add_regdst");
    push(S_WB, 32'd12, "add_wb");
    push(S_MEMWR, 32'd0, "add_memwr");
    drain();
    drive(OP_R, 6'b100100, 32'h0000F0F0, 32'h0000FF00, 32'd0);
    push(S_ALU, 32'h0000F000, "and_alu");
    drain();
    drive(OP_R, 6'b100101, 32'h0000F0F0, 32'h0000FF00, 32'd0);
    push(S_ALU, 32'h0000FFF0, "or_alu");
    drain();
    drive(OP_R, 6'b100010, 32'd3, 32'd5, 32'd0);
    push(S_ALU, 32'hFFFFFFFE, "sub_alu");
    drain();
    drive(OP_R, 6'b000111, 32'd3, 32'd5, 32'd0);
    push(S_ALU, 32'd8, "unk_funct_add");
    drain();

    // slt signed
    drive(OP_R, 6'b101010, 32'hFFFFFFFF, 32'd1, 32'd0);
    push(S_ALU, 32'd1, "slt_lt");
    push(S_ZERO, 32'd0, "slt_lt_zero");
    drain();
    drive(OP_R, 6'b101010, 32'd1, 32'hFFFFFFFF, 32'd0);
    push(S_ALU, 32'd0, "slt_ge");
    push(S_ZERO, 32'd1, "slt_ge_zero");
    drain();

    // Store then load, including wrapped address
    @(negedge clk);
    drive(OP_SW, 6'd0, 32'd0, 32'hDEADBEEF, 32'd8);
    push(S_RDATA, 32'd0, "sw_before_edge");
    push(S_REGDST, 32'd0, "sw_regdst");
    drain();
    @(posedge clk);
    #1;
    push(S_RDATA, 32'hDEADBEEF, "sw_after_edge");
    drain();
    load(32'd0, 32'd8, 32'hDEADBEEF, "lw8");
    load(32'h100, 32'd8, 32'hDEADBEEF, "lw108");
    push(S_REGWR, 32'd1, "lw_regwr");
    push(S_REGDST, 32'd0, "lw_regdst");
    drain();

    // beq
    drive(OP_BEQ, 6'd0, 32'd9, 32'd9, 32'd4);
    push(S_ZERO, 32'd1, "beq_eq_zero");
    push(S_BRANCH, 32'd1, "beq_branch");
    push(S_PCSRC, 32'd1, "beq_pcsrc");
    push(S_REGWR, 32'd0, "beq_regwr");
    drain();
    drive(OP_BEQ, 6'd0, 32'd9, 32'd8, 32'd4);
    push(S_PCSRC, 32'd0, "beq_ne_pcsrc");
    push(S_ALU, 32'd1, "beq_ne_alu");
    drain();

    // Reset mid-operation
    store(32'd12, 32'h00001234);
    load(32'd0, 32'd12, 32'h00001234, "w3_pre");
    @(negedge clk);
    drive(OP_SW, 6'd0, 32'd0, 32'h00005555, 32'd12);
    #2 rst_n = 1'b0;
    push(S_RDATA, 32'd0, "rst_rdata");
    push(S_MEMWR, 32'd1, "rst_memwr_follows");
    drain();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(OP_LW, 6'd0, 32'd0, 32'd0, 32'd12);
    push(S_RDATA, 32'd0, "w3_post_rst");
    drain();
    load(32'd0, 32'd8, 32'd0, "w2_post_rst");
    store(32'd16, 32'hCAFEF00D);
    load(32'd0, 32'd16, 32'hCAFEF00D, "first_write");

    // Illegal opcode: no controls, no write
    @(negedge clk);
    drive(OP_BAD, 6'b100010, 32'd20, 32'd0, 32'd0);
    rd2 = 32'hA5A5A5A5; rd1 = 32'd0; imm_ext = 32'd20;
    push(S_REGDST, 32'd0, "bad_regdst");
    push(S_REGWR, 32'd0, "bad_regwr");
    push(S_BRANCH, 32'd0, "bad_branch");
    push(S_MEMWR, 32'd0, "bad_memwr");
    push(S_PCSRC, 32'd0, "bad_pcsrc");
    push(S_ALU, 32'hA5A5A5A5, "bad_alu_add");
    drain();
    @(posedge clk);
    load(32'd0, 32'd20, 32'd0, "bad_nowrite");
    load(32'd0, 32'h24, 32'd0, "bad_nowrite_a5");

    // addi
    @(negedge clk);
    drive(OP_ADDI, 6'd0, 32'hFFFFFFFD, 32'd77, 32'hFFFFFFFE);
    push(S_ALU, 32'hFFFFFFFB, "addi_alu");
    push(S_REGDST, 32'd0, "addi_regdst");
    push(S_REGWR, 32'd1, "addi_regwr");
    push(S_WB, 32'hFFFFFFFB, "addi_wb");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
